// File: rtl/lv_wdg_scan.sv
// Background register-integrity scanner: periodically reads a register window through
// the register access controller and checks each value against its stored CRC-8.
module lv_wdg_scan #(
    parameter int                 REG_AW          = 7,
    parameter int                 REG_DW          = 8,
    parameter int                 REG_CRC_W       = 8,
    parameter logic [REG_AW-1:0]  SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0]  SCAN_END_ADDR   = 7'h3F,
    parameter int                 SCAN_INTV_CYC   = 1024,
    parameter int                 ACK_TIMEOUT_CYC = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    input  logic                 i_spi_rst_wdg,
    input  logic                 i_err_clr,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
    output logic                 o_scan_crc_err,
    output logic                 o_scan_tmo_err,
    output logic [REG_AW-1:0]    o_scan_err_addr,
    output logic                 o_scan_done
);

    localparam int INTV_W = $clog2(SCAN_INTV_CYC + 1);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT_CYC + 1);
    localparam logic [INTV_W-1:0] INTV_LAST = INTV_W'(SCAN_INTV_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [INTV_W-1:0]      intv_cnt_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic                   tmo_hit_r;
    logic [REG_DW-1:0]      cap_data_r;
    logic [REG_CRC_W-1:0]   cap_crc_r;
    logic                   rd_req_r;
    logic [REG_AW-1:0]      addr_r;
    logic                   done_r;
    logic                   crc_err_r;
    logic                   tmo_err_r;
    logic [REG_AW-1:0]      err_addr_r;
    logic [REG_CRC_W-1:0]   crc_calc_s;
    logic                   crc_ev_s;
    logic                   tmo_ev_s;

    // CRC-8, poly 0x07, init 0x00, MSB first, no reflection, no final XOR
    function automatic logic [REG_CRC_W-1:0] crc8_calc(input logic [REG_DW-1:0] data);
        logic [REG_CRC_W-1:0] crc;
        logic                 fb;
        crc = 8'h00;
        for (int i = REG_DW - 1; i >= 0; i--) begin
            fb  = crc[7] ^ data[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc;
    endfunction

    // Error events raised during the check cycle; a timeout entry skips the compare.
    always_comb begin
        crc_calc_s = crc8_calc(cap_data_r);
        crc_ev_s   = 1'b0;
        tmo_ev_s   = 1'b0;
        if (state_r == ST_CHK) begin
            tmo_ev_s = tmo_hit_r;
            crc_ev_s = !tmo_hit_r && (crc_calc_s != cap_crc_r);
        end else begin
            tmo_ev_s = 1'b0;
            crc_ev_s = 1'b0;
        end
    end

    // Scan sequencer: interval wait, read handshake with timeout, check and address walk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            intv_cnt_r <= '0;
            tmo_cnt_r  <= '0;
            tmo_hit_r  <= 1'b0;
            cap_data_r <= '0;
            cap_crc_r  <= '0;
            rd_req_r   <= 1'b0;
            addr_r     <= SCAN_START_ADDR;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rd_req_r <= 1'b0;
                    if (i_scan_en) begin
                        addr_r     <= SCAN_START_ADDR;
                        intv_cnt_r <= '0;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!i_scan_en) begin
                        state_r <= ST_IDLE;
                    end else if (i_spi_rst_wdg) begin
                        intv_cnt_r <= '0;
                    end else if (intv_cnt_r == INTV_LAST) begin
                        tmo_cnt_r <= '0;
                        rd_req_r  <= 1'b1;
                        state_r   <= ST_REQ;
                    end else begin
                        intv_cnt_r <= intv_cnt_r + INTV_W'(1);
                    end
                end
                ST_REQ: begin
                    // An ack coinciding with the last timeout cycle still counts as a good read.
                    if (i_rac_wdg_scan_ack) begin
                        cap_data_r <= i_rac_wdg_scan_data;
                        cap_crc_r  <= i_rac_wdg_scan_crc;
                        tmo_hit_r  <= 1'b0;
                        rd_req_r   <= 1'b0;
                        state_r    <= ST_CHK;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        tmo_hit_r <= 1'b1;
                        rd_req_r  <= 1'b0;
                        state_r   <= ST_CHK;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_CHK: begin
                    if (addr_r == SCAN_END_ADDR) begin
                        done_r     <= 1'b1;
                        addr_r     <= SCAN_START_ADDR;
                        intv_cnt_r <= '0;
                        state_r    <= i_scan_en ? ST_WAIT : ST_IDLE;
                    end else begin
                        addr_r <= addr_r + REG_AW'(1);
                        if (i_scan_en) begin
                            tmo_cnt_r <= '0;
                            rd_req_r  <= 1'b1;
                            state_r   <= ST_REQ;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    rd_req_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; the first error address is kept until a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_err_r  <= 1'b0;
            tmo_err_r  <= 1'b0;
            err_addr_r <= '0;
        end else begin
            crc_err_r <= crc_ev_s | (crc_err_r & ~i_err_clr);
            tmo_err_r <= tmo_ev_s | (tmo_err_r & ~i_err_clr);
            if ((crc_ev_s || tmo_ev_s) && (i_err_clr || (!crc_err_r && !tmo_err_r))) begin
                err_addr_r <= addr_r;
            end
        end
    end

    assign o_wdg_scan_rac_rd_req = rd_req_r;
    assign o_wdg_scan_rac_addr   = addr_r;
    assign o_scan_crc_err        = crc_err_r;
    assign o_scan_tmo_err        = tmo_err_r;
    assign o_scan_err_addr       = err_addr_r;
    assign o_scan_done           = done_r;

endmodule

// File: tb/tb_lv_wdg_scan.sv
// Directed bench for lv_wdg_scan: a 3-register window, 4-cycle interval, 64-cycle ack timeout.
module tb_lv_wdg_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_en = 1'b0;
    logic       spi_rst_wdg = 1'b0;
    logic       err_clr = 1'b0;
    logic       rd_req;
    logic [6:0] addr;
    logic       ack = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] crc = 8'h00;
    logic       crc_err;
    logic       tmo_err;
    logic [6:0] err_addr;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    lv_wdg_scan #(
        .REG_AW(7), .REG_DW(8), .REG_CRC_W(8),
        .SCAN_START_ADDR(7'h00), .SCAN_END_ADDR(7'h02),
        .SCAN_INTV_CYC(4), .ACK_TIMEOUT_CYC(64)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_scan_en(scan_en),
        .i_spi_rst_wdg(spi_rst_wdg),
        .i_err_clr(err_clr),
        .o_wdg_scan_rac_rd_req(rd_req),
        .o_wdg_scan_rac_addr(addr),
        .i_rac_wdg_scan_ack(ack),
        .i_rac_wdg_scan_data(data),
        .i_rac_wdg_scan_crc(crc),
        .o_scan_crc_err(crc_err),
        .o_scan_tmo_err(tmo_err),
        .o_scan_err_addr(err_addr),
        .o_scan_done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int budget, output int cyc);
        cyc = 0;
        while (!rd_req && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check_val("req_seen", {31'd0, rd_req}, 32'd1);
    endtask

    // One read: ack two cycles after the request, then check the flags after the check cycle.
    task automatic serve(input logic [6:0] e_addr, input logic [7:0] d, input logic [7:0] c,
                         input logic clr, input logic e_crc, input logic e_tmo,
                         input logic [6:0] e_eaddr, input logic e_done);
        int cyc;
        wait_req(20, cyc);
        check_val("rd_addr", {25'd0, addr}, {25'd0, e_addr});
        @(negedge clk);
        check_val("req_hold", {31'd0, rd_req}, 32'd1);
        ack = 1'b1; data = d; crc = c;
        @(negedge clk);
        ack = 1'b0; data = 8'h00; crc = 8'h00;
        check_val("req_drop", {31'd0, rd_req}, 32'd0);
        err_clr = clr;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("crc_err", {31'd0, crc_err}, {31'd0, e_crc});
        check_val("tmo_err", {31'd0, tmo_err}, {31'd0, e_tmo});
        check_val("err_addr", {25'd0, err_addr}, {25'd0, e_eaddr});
        check_val("done", {31'd0, done}, {31'd0, e_done});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int hits;
        int n;

        repeat (3) @(negedge clk);
        check_val("rst_req", {31'd0, rd_req}, 32'd0);
        check_val("rst_addr", {25'd0, addr}, 32'd0);
        check_val("rst_flags", {30'd0, crc_err, tmo_err}, 32'd0);
        check_val("rst_eaddr", {25'd0, err_addr}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass 1: clean pass, IDLE -> WAIT (4 cycles) -> REQ
        scan_en = 1'b1;
        wait_req(20, cyc);
        check_val("intv_lat", cyc, 32'd5);
        serve(7'h00, 8'h01, 8'h07, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
        serve(7'h01, 8'h80, 8'h89, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
        serve(7'h02, 8'h03, 8'h09, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
        @(negedge clk);
        check_val("done_pulse", {31'd0, done}, 32'd0);

        // Pass 2: CRC error at 0x01 is kept over a later one at 0x02
        serve(7'h00, 8'h01, 8'h07, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
        serve(7'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 7'h01, 1'b0);
        serve(7'h02, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 7'h01, 1'b1);

        // Pass 3: clear coinciding with a new error -> new error and address win
        serve(7'h00, 8'h01, 8'h07, 1'b0, 1'b1, 1'b0, 7'h01, 1'b0);
        serve(7'h01, 8'h80, 8'h89, 1'b0, 1'b1, 1'b0, 7'h01, 1'b0);
        serve(7'h02, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 7'h02, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("clr_flag", {31'd0, crc_err}, 32'd0);
        check_val("clr_eaddr", {25'd0, err_addr}, 32'd2);

        // Pass 4: no ack at 0x00 -> 64-cycle request, timeout flag, scan continues
        wait_req(20, cyc);
        n = 0;
        while (rd_req && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_val("tmo_len", n, 32'd64);
        @(negedge clk);
        check_val("tmo_flag", {31'd0, tmo_err}, 32'd1);
        check_val("tmo_crcflag", {31'd0, crc_err}, 32'd0);
        check_val("tmo_eaddr", {25'd0, err_addr}, 32'd0);
        serve(7'h01, 8'h80, 8'h89, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
        serve(7'h02, 8'h03, 8'h09, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1);

        // Watchdog restart every 3 cycles holds off the request
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            spi_rst_wdg = 1'b1;
            @(negedge clk);
            spi_rst_wdg = 1'b0;
            if (rd_req) hits++;
            @(negedge clk);
            if (rd_req) hits++;
            @(negedge clk);
            if (rd_req) hits++;
        end
        check_val("wdg_hold", hits, 32'd0);
        spi_rst_wdg = 1'b1;
        @(negedge clk);
        spi_rst_wdg = 1'b0;
        wait_req(20, cyc);
        // pulse cycle plus four counted WAIT cycles
        check_val("wdg_lat", cyc + 1, 32'd5);

        // Enable dropped with a read pending: read completes, then idle
        scan_en = 1'b0;
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!rd_req || addr != 7'h00) hits++;
        end
        check_val("en_hold", hits, 32'd0);
        ack = 1'b1; data = 8'h01; crc = 8'h07;
        @(negedge clk);
        ack = 1'b0;
        check_val("en_drop", {31'd0, rd_req}, 32'd0);
        @(negedge clk);
        check_val("en_addr", {25'd0, addr}, 32'd1);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            // stray ack with a bad CRC outside a read must be ignored
            ack = (i == 10);
            data = 8'h01; crc = 8'h00;
            @(negedge clk);
            if (rd_req) hits++;
        end
        ack = 1'b0;
        @(negedge clk);
        check_val("idle_noreq", hits, 32'd0);
        check_val("stray_ack", {31'd0, crc_err}, 32'd0);

        // Reset in the middle of a read drops the request at once
        scan_en = 1'b1;
        wait_req(20, cyc);
        check_val("rearm_addr", {25'd0, addr}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_req", {31'd0, rd_req}, 32'd0);
        check_val("arst_flags", {30'd0, crc_err, tmo_err}, 32'd0);
        @(negedge clk);
        scan_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst", {31'd0, rd_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lv_wdg_scan.md
LV_WDG_SCAN -- requirements
Module: lv_wdg_scan

Interface
REQ-001 Parameter REG_AW, default 7, register address width.
REQ-002 Parameter REG_DW, default 8, register data width.
REQ-003 Parameter REG_CRC_W, default 8, stored CRC width; fixed at 8.
REQ-004 Parameter SCAN_START_ADDR, default 7'h00, first address scanned.
REQ-005 Parameter SCAN_END_ADDR, default 7'h3F, last address scanned; SCAN_END_ADDR >= SCAN_START_ADDR.
REQ-006 Parameter SCAN_INTV_CYC, default 1024, idle cycles between scan passes; value >= 1.
REQ-007 Parameter ACK_TIMEOUT_CYC, default 64, maximum cycles to wait for a read ack.
REQ-008 i_clk  in  1  single clock; one clock only.
REQ-009 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-010 i_scan_en  in  1  scan enable, level.
REQ-011 i_spi_rst_wdg  in  1  one-cycle pulse; restarts the interval counter.
REQ-012 i_err_clr  in  1  one-cycle pulse; clears the sticky error flags.
REQ-013 o_wdg_scan_rac_rd_req  out  1  read request to the register access controller.
REQ-014 o_wdg_scan_rac_addr  out  REG_AW  read address.
REQ-015 i_rac_wdg_scan_ack  in  1  read ack, one-cycle pulse.
REQ-016 i_rac_wdg_scan_data  in  REG_DW  read data, valid with ack.
REQ-017 i_rac_wdg_scan_crc  in  REG_CRC_W  stored CRC, valid with ack.
REQ-018 o_scan_crc_err  out  1  sticky CRC mismatch flag.
REQ-019 o_scan_tmo_err  out  1  sticky ack-timeout flag.
REQ-020 o_scan_err_addr  out  REG_AW  address of the first error since the last clear.
REQ-021 o_scan_done  out  1  one-cycle pulse at the end of each full pass.

Function
REQ-022 FSM states: IDLE, WAIT, REQ, CHK; all outputs registered.
REQ-023 IDLE: when i_scan_en=1, load addr=SCAN_START_ADDR and interval counter=0, then go to WAIT.
REQ-024 WAIT: counter increments each cycle; at count SCAN_INTV_CYC-1, go to REQ.
REQ-025 WAIT: i_spi_rst_wdg=1 forces the counter to 0.
REQ-026 WAIT: i_scan_en=0 returns to IDLE next cycle.
REQ-027 REQ: rd_req is held at 1 with a stable address until ack or timeout; the arbiter may stall the grant indefinitely.
REQ-028 REQ: the timeout counter clears on REQ entry; at ACK_TIMEOUT_CYC cycles without ack, drop rd_req and go to CHK flagged as timeout.
REQ-029 Ack in cycle T: drop rd_req at T+1, capture data and crc at T, and be in CHK at T+1.
REQ-030 Ack in the same cycle as timeout expiry: the ack wins and no timeout is flagged.
REQ-031 CHK: compute CRC-8 over captured data, MSB first, poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
REQ-032 CHK: compare the computed CRC with the captured crc; a mismatch sets o_scan_crc_err at T+2.
REQ-033 CHK on a timeout entry: skip the compare and set o_scan_tmo_err.
REQ-034 o_scan_err_addr: loaded with the current address on an error only when both flags are 0 (first error is kept).
REQ-035 i_err_clr clears both flags; a new error in the same cycle wins (flag set, addr loaded).
REQ-036 CHK exit, addr < SCAN_END_ADDR: increment addr, then go to REQ if i_scan_en=1, else to IDLE.
REQ-037 CHK exit, addr == SCAN_END_ADDR: pulse o_scan_done at T+2, wrap addr to SCAN_START_ADDR, clear the counter, then go to WAIT if i_scan_en=1, else to IDLE.
REQ-038 i_scan_en=0 during REQ: complete the current read (ack or timeout) and CHK before returning to IDLE; never drop rd_req before ack or timeout.
REQ-039 Ack received outside REQ: ignored.

Reset
REQ-040 While i_rst_n=0: state=IDLE; rd_req=0; addr=SCAN_START_ADDR; both flags=0; err_addr=0; done=0; all counters=0.
REQ-041 Reset asserted mid-read: rd_req drops immediately (asynchronously); no flag update occurs.

Verification
REQ-042 Scenario: en=1, SCAN_INTV_CYC=4, range 0x00-0x02, ack 2 cycles after each req with correct CRC -> 3 reads at addr 0,1,2; done pulses once; flags stay 0.
REQ-043 Scenario: data 0x01 returned with crc 0x00 at addr 0x01 (correct CRC is 0x07) -> crc_err=1 and err_addr=0x01; a later error at 0x02 leaves err_addr=0x01.
REQ-044 Scenario: no ack at addr 0x00, ACK_TIMEOUT_CYC=64 -> rd_req drops after 64 cycles, tmo_err=1, and the scan continues at 0x01.
REQ-045 Scenario: i_err_clr in the same cycle as a new CRC error -> crc_err stays 1 and err_addr takes the new address.
REQ-046 Scenario: i_spi_rst_wdg pulsed every 3 cycles in WAIT with SCAN_INTV_CYC=4 -> no rd_req is issued; stopping the pulses -> rd_req 4 cycles after the last pulse.
REQ-047 Scenario: en deasserted while rd_req is pending -> rd_req holds until ack, CHK runs, then IDLE; no further requests are issued.
